// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared types and constants for the bit-serial adder.
//   sa_state_e   - FSM state encoding (IDLE / RUN / DONE)
//   SA_DEFAULT_N - default operand/result width
package serial_adder_pkg;

    localparam int unsigned SA_DEFAULT_N = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sa_state_e;

endpackage : serial_adder_pkg

// File: rtl/serial_adder_fa.sv
// full_adder1: single-bit full adder, the per-bit datapath of serial_adder.
//   a, b, ci : addend bits and carry-in
//   s, co    : sum bit and carry-out (combinational)
module full_adder1 (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule : full_adder1

// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder, LSB first, one bit per clock.
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : new operation request, accepted only in IDLE
//   x, y, cIn    : operands and carry-in, captured on the accepted start
//   op           : (SERIAL_ADDER_SUB_EN builds only) 1 = x - y - cIn
//   busy         : high while bits are being processed
//   done         : one-cycle pulse, N+1 cycles after start is accepted
//   z, c, v      : sum, carry (borrow when subtracting), signed overflow;
//                  held from done until the next completion
// Build option: define SERIAL_ADDER_SUB_EN to add the op port (subtraction).
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned N = SA_DEFAULT_N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         cIn,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic         op,
`endif
    output logic         busy,
    output logic         done,
    output logic [N-1:0] z,
    output logic         c,
    output logic         v
);

    localparam int unsigned    CW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0]  LAST = CW'(N - 1);

    sa_state_e     state_q, state_d;
    logic [N-1:0]  xs_q;      // x shifts out LSB-first while sum bits shift in at the MSB
    logic [N-1:0]  ys_q;
    logic          cy_q;
    logic          sub_q;
    logic [CW-1:0] cnt_q;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [N-1:0]  z_q;
    logic          c_q, v_q;

    logic          sub_in;
    logic          accept, step, last_bit;
    logic          fa_b, fa_s, fa_co;

`ifdef SERIAL_ADDER_SUB_EN
    assign sub_in = op;
`else
    assign sub_in = 1'b0;
`endif

    assign last_bit = (cnt_q == LAST);

    // Subtraction feeds ~y; the carry chain is seeded with ~cIn at accept.
    assign fa_b = ys_q[0] ^ sub_q;

    full_adder1 u_fa (
        .a  (xs_q[0]),
        .b  (fa_b),
        .ci (cy_q),
        .s  (fa_s),
        .co (fa_co)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start)    state_d = RUN;
            RUN:     if (last_bit) state_d = DONE;
            DONE:                  state_d = IDLE;
            default:               state_d = IDLE;
        endcase
    end

    // Output / datapath-control decode
    always_comb begin
        accept = 1'b0;
        step   = 1'b0;
        busy_d = 1'b0;
        done_d = 1'b0;
        accept = (state_q == IDLE) && start;
        step   = (state_q == RUN);
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xs_q   <= '0;
            ys_q   <= '0;
            cy_q   <= 1'b0;
            sub_q  <= 1'b0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            z_q    <= '0;
            c_q    <= 1'b0;
            v_q    <= 1'b0;
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
            if (accept) begin
                xs_q  <= x;
                ys_q  <= y;
                cy_q  <= cIn ^ sub_in;
                sub_q <= sub_in;
                cnt_q <= '0;
            end else if (step) begin
                xs_q <= {fa_s, xs_q[N-1:1]};
                ys_q <= {1'b0, ys_q[N-1:1]};
                cy_q <= fa_co;
                if (last_bit) begin
                    z_q <= {fa_s, xs_q[N-1:1]};
                    c_q <= fa_co ^ sub_q;
                    // cy_q is the carry into the MSB on this edge
                    v_q <= cy_q ^ fa_co;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign z    = z_q;
    assign c    = c_q;
    assign v    = v_q;

endmodule : serial_adder

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter: N, 8, operand/result bit width (N >= 2).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: start  input  1  request a new operation; sampled only in IDLE.
REQ-005 SHALL have port: x  input  N  first operand; captured on the accepted start.
REQ-006 SHALL have port: y  input  N  second operand; captured on the accepted start.
REQ-007 SHALL have port: cIn  input  1  carry-in; captured on the accepted start.
REQ-008 SHALL have port: busy  output  1  high while in RUN.
REQ-009 SHALL have port: done  output  1  single-cycle pulse marking a valid result.
REQ-010 SHALL have port: z  output  N  sum x + y + cIn, modulo 2^N.
REQ-011 SHALL have port: c  output  1  carry out of the MSB.
REQ-012 SHALL have port: v  output  1  signed overflow flag.

Function
REQ-013 SHALL implement a 3-state FSM with states IDLE, RUN and DONE.
REQ-014 SHALL, when start=1 is sampled in IDLE, capture x, y and cIn, clear the bit counter, and enter RUN.
REQ-015 SHALL, on each RUN edge, add one bit (LSB first) with a 1-bit full adder, shift that sum bit into the result register, and register the carry.
REQ-016 SHALL, on the RUN edge that processes bit N-1, update z, c and v, then enter DONE.
REQ-017 SHALL assert done only in DONE, for exactly one cycle; the first done=1 cycle is N+1 cycles after the start-accept edge.
REQ-018 SHALL return from DONE to IDLE unconditionally; start sampled in DONE is ignored.
REQ-019 SHALL ignore start and input changes while in RUN; the operands captured at start are used.
REQ-020 SHALL hold z, c and v stable from done until the next completion; they are not updated mid-operation.
REQ-021 SHALL compute v = (carry into the MSB) XOR (carry out of the MSB).
REQ-022 SHALL size the bit counter to ceil(log2(N)) bits; the counter does not wrap within an operation.

Reset
REQ-023 SHALL, on rst_n=0 at any time (including mid-RUN), immediately enter IDLE with busy=0, done=0, z=0, c=0, v=0 and the counter at 0.
REQ-024 SHALL discard an operation interrupted by reset; no done is produced for it.

Configuration
REQ-025 SHALL add, when SERIAL_ADDER_SUB_EN is defined, the input port "op  input  1", captured on start: 1 selects x - y - cIn, computed as x + ~y + ~cIn with cIn acting as the borrow-in, and c then reports borrow-out (inverted carry).
REQ-026 SHALL, when SERIAL_ADDER_SUB_EN is undefined, omit the op port, leave add-only behaviour unchanged, and keep latency identical in both builds.

Structure
REQ-027 SHALL place the FSM state enum (IDLE/RUN/DONE) and the default width constant in the shared package serial_adder_pkg.
REQ-028 SHALL instantiate a single sub-module full_adder1 (a, b, ci -> s, co) as the per-bit datapath.

Verification
REQ-029 SHALL cover: x=15, y=5, cIn=0, start -> done at cycle N+1, z=20, c=0, v=0.
REQ-030 SHALL cover: x=8'h7F, y=8'h01, cIn=0 -> z=8'h80, c=0, v=1.
REQ-031 SHALL cover: x=8'hFF, y=8'h01, cIn=0 -> z=0, c=1, v=0; and x=8'hF0, y=8'h0F, cIn=1 -> z=0, c=1, v=0.
REQ-032 SHALL cover: start with x=1, y=2, then a second start and changed x during RUN -> single done, z=3, busy high for exactly N cycles.
REQ-033 SHALL cover: rst_n pulsed low at RUN bit 3 -> outputs 0 immediately, no done; a subsequent start (x=20, y=5) -> z=25.
REQ-034 SHALL cover, in a SERIAL_ADDER_SUB_EN build: op=1, x=5, y=10, cIn=0 -> z=251, c(borrow)=1, v=0.
